vector_addition_writeback_buffer: RTL and testbench

Downstream stage of the vector integer addition unit. Captures each 128-bit add/sub or carry result, merges masked-off elements with the old destination value (mask-undisturbed), and queues the merged result in a small FIFO. The FIFO feeds the vector register file write port through a valid/ready handshake, so a stalled write port never drops an adder result.

---
 rtl/vector_addition_writeback_buffer.sv | 134 +++++++++++++
 tb/tb_vector_addition_writeback_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_addition_writeback_buffer.sv
// vector_addition_writeback_buffer
//
// Last stage of the vector integer addition unit. The adder result is merged
// with the old destination value: masked-off elements keep the old value, and
// for carry/borrow results only the low N bits come from the adder. The merged
// result is queued in a small FIFO, which feeds the vector register file write
// port. A stalled write port therefore never drops an adder result.
//
// Handshakes (both sides use strict valid/ready):
//   A transfer happens on the rising edge where valid and ready are both 1.
//   The producer keeps its data stable while valid=1 and ready=0. Upstream may
//   drop valid_i without a transfer. ready_o depends only on occupancy, never
//   on ready_i, so there is no combinational path from ready_i to ready_o.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               synchronous flush of all queued entries
//   valid_i / ready_o     input handshake (ready_o = not full)
//   vd_i, vd_old_i        adder result and previous destination contents
//   vmask_i               per-element mask, element k uses bit k
//   vsew_i                element width: 00=8b 01=16b 10=32b 11=64b
//   masked_i              1 = masked op, 0 = all elements active
//   compute_carry_i       1 = result is a carry/borrow mask (N bits)
//   vd_addr_i             destination register index
//   valid_o / ready_i     write-port handshake for the head entry
//   wb_data_o, wb_addr_o  head entry data and index (0 when empty)
//   count_o               current occupancy
module vector_addition_writeback_buffer #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [127:0]          vd_i,
  input  logic [127:0]          vd_old_i,
  input  logic [15:0]           vmask_i,
  input  logic [1:0]            vsew_i,
  input  logic                  masked_i,
  input  logic                  compute_carry_i,
  input  logic [ADDR_WIDTH-1:0] vd_addr_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [127:0]          wb_data_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [CNT_WIDTH-1:0]  count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Element index that owns a given bit of the 128-bit vector.
  function automatic logic [3:0] elem_of(input logic [6:0] bit_idx,
                                         input logic [1:0] sew);
    logic [3:0] k;
    case (sew)
      2'b00:   k = bit_idx[6:3];
      2'b01:   k = {1'b0, bit_idx[6:4]};
      2'b10:   k = {2'b00, bit_idx[6:5]};
      default: k = {3'b000, bit_idx[6]};
    endcase
    return k;
  endfunction

  logic [127:0]          w_merged;
  logic [4:0]            w_num_elem;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;

  logic [127:0]          r_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr_q [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;

  // Merge on the input side so each stored entry is already final write data.
  always_comb begin
    w_num_elem = 5'd16 >> vsew_i;
    w_merged   = vd_i;
    for (int b = 0; b < 128; b++) begin
      if (compute_carry_i) begin
        // Carry mask occupies bits [N-1:0]; the tail is left undisturbed.
        w_merged[b] = (7'(b) < {2'b00, w_num_elem}) ? vd_i[b] : vd_old_i[b];
      end else if (masked_i) begin
        w_merged[b] = vmask_i[elem_of(7'(b), vsew_i)] ? vd_i[b] : vd_old_i[b];
      end
    end
  end

  // Full/empty come from the counter; pointers alone are ambiguous.
  assign w_full  = (r_count == CNT_WIDTH'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = valid_i && !w_full;
  assign w_pop   = !w_empty && ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_data_q[r_wr_ptr] <= w_merged;
      r_addr_q[r_wr_ptr] <= vd_addr_i;
    end
  end

  assign ready_o   = !w_full;
  assign valid_o   = !w_empty;
  assign count_o   = r_count;
  assign wb_data_o = w_empty ? '0 : r_data_q[r_rd_ptr];
  assign wb_addr_o = w_empty ? '0 : r_addr_q[r_rd_ptr];

endmodule

// File: tb/tb_vector_addition_writeback_buffer.sv
module tb_vector_addition_writeback_buffer;

  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int CW    = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [127:0]  vd_i = '0;
  logic [127:0]  vd_old_i = '0;
  logic [15:0]   vmask_i = '0;
  logic [1:0]    vsew_i = '0;
  logic          masked_i = 1'b0;
  logic          compute_carry_i = 1'b0;
  logic [AW-1:0] vd_addr_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [127:0]  wb_data_o;
  logic [AW-1:0] wb_addr_o;
  logic [CW-1:0] count_o;

  int checks = 0;
  int errors = 0;
  logic [132:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  vector_addition_writeback_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .vd_i(vd_i), .vd_old_i(vd_old_i), .vmask_i(vmask_i), .vsew_i(vsew_i),
    .masked_i(masked_i), .compute_carry_i(compute_carry_i), .vd_addr_i(vd_addr_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o), .count_o(count_o)
  );

  // ---------------- reference model ----------------
  function automatic logic [127:0] ref_merge(input logic [127:0] vd, input logic [127:0] old,
                                             input logic [15:0] mask, input logic [1:0] sew,
                                             input logic masked, input logic carry);
    int n;
    int ew;
    logic [127:0] r;
    n  = 16 >> sew;
    ew = 128 / n;
    r  = vd;
    for (int b = 0; b < 128; b++) begin
      if (carry)       r[b] = (b < n) ? vd[b] : old[b];
      else if (masked) r[b] = mask[b / ew] ? vd[b] : old[b];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare DUT status against the model's occupancy (called just after an edge).
  task automatic chk_status();
    int n;
    n = exp_q.size();
    chk("count", 133'(count_o), 133'(n));
    chk("valid_o", 133'(valid_o), 133'(n != 0));
    chk("ready_o", 133'(ready_o), 133'(n < DEPTH));
    if (n == 0) chk("empty_out_zero", {wb_addr_o, wb_data_o}, 133'd0);
  endtask

  // ---------------- driver ----------------
  // Called right after a rising edge; returns right after the next one.
  task automatic step(input logic v, input logic f, input logic r,
                      input logic [127:0] vd, input logic [127:0] old,
                      input logic [15:0] m, input logic [1:0] sew,
                      input logic msk, input logic cry, input logic [AW-1:0] addr);
    #1;
    chk_status();
    valid_i = v; flush_i = f; ready_i = r;
    vd_i = vd; vd_old_i = old; vmask_i = m; vsew_i = sew;
    masked_i = msk; compute_carry_i = cry; vd_addr_i = addr;
    @(negedge clk_i);
    if (v && !f && ready_o) exp_q.push_back({addr, ref_merge(vd, old, m, sew, msk, cry)});
    @(posedge clk_i);
    if (f) exp_q.delete();
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, r, '0, '0, '0, 2'b00, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic         held = 1'b0;
  logic [132:0] held_val;

  always @(negedge clk_i) begin
    if (rst_i) begin
      held = 1'b0;
    end else begin
      if (held && valid_o) chk("hold_stable", {wb_addr_o, wb_data_o}, held_val);
      held = 1'b0;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_entry: got %h expected no entry", {wb_addr_o, wb_data_o});
        end else begin
          chk("wb_entry", {wb_addr_o, wb_data_o}, exp_q.pop_front());
        end
      end else if (valid_o) begin
        held = 1'b1;
        held_val = {wb_addr_o, wb_data_o};
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("rst_valid", 133'(valid_o), 133'd0);
    chk("rst_ready", 133'(ready_o), 133'd1);
    chk("rst_count", 133'(count_o), 133'd0);
    chk("rst_data", {wb_addr_o, wb_data_o}, 133'd0);
    @(posedge clk_i);
    idle(1'b1);

    // Masked byte merge: low 8 elements from vd, high 8 from old.
    step(1'b1, 1'b0, 1'b1, {16{8'hAA}}, {16{8'h55}}, 16'h00FF, 2'b00, 1'b1, 1'b0, 5'd7);
    #1 chk("mask_merge", 133'(wb_data_o), 133'({64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA}));
    idle(1'b1);
    idle(1'b1);

    // Carry result at 32-bit elements: low 4 bits from vd, tail from old.
    step(1'b1, 1'b0, 1'b0, 128'hF, ~128'h1, 16'h0000, 2'b10, 1'b1, 1'b1, 5'd9);
    #1 chk("carry_merge", 133'(wb_data_o), 133'({128{1'b1}}));
    idle(1'b1);
    idle(1'b1);

    // Fill with write port stalled; third push refused.
    for (int i = 1; i <= 3; i++)
      step(1'b1, 1'b0, 1'b0, rnd128(), rnd128(), 16'($urandom), 2'($urandom), 1'b1, 1'b0, 5'(i));
    #1;
    chk("full_ready_low", 133'(ready_o), 133'd0);
    chk("full_head_addr", 133'(wb_addr_o), 133'd1);
    // Full with push and pop together: pop only.
    step(1'b1, 1'b0, 1'b1, rnd128(), rnd128(), '0, 2'b00, 1'b0, 1'b0, 5'd4);
    #1 chk("full_pop_only", 133'(count_o), 133'd1);
    idle(1'b1);
    idle(1'b1);

    // Random back-to-back traffic with random write-port stalls.
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 3) != 0, rnd128(), rnd128(),
           16'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 5'($urandom));
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      idle(1'b1);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
    end
    idle(1'b1);

    // Flush with two queued entries and a concurrent push.
    step(1'b1, 1'b0, 1'b0, rnd128(), rnd128(), '0, 2'b01, 1'b0, 1'b0, 5'd11);
    step(1'b1, 1'b0, 1'b0, rnd128(), rnd128(), '0, 2'b01, 1'b0, 1'b0, 5'd12);
    step(1'b1, 1'b1, 1'b0, rnd128(), rnd128(), '0, 2'b01, 1'b0, 1'b0, 5'd13);
    #1;
    chk("flush_count", 133'(count_o), 133'd0);
    chk("flush_valid", 133'(valid_o), 133'd0);
    idle(1'b1);

    // Reset asserted while draining.
    step(1'b1, 1'b0, 1'b0, rnd128(), rnd128(), '0, 2'b11, 1'b0, 1'b0, 5'd21);
    step(1'b1, 1'b0, 1'b0, rnd128(), rnd128(), '0, 2'b11, 1'b0, 1'b0, 5'd22);
    step(1'b0, 1'b0, 1'b1, '0, '0, '0, 2'b00, 1'b0, 1'b0, '0);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async_valid", 133'(valid_o), 133'd0);
    chk("rst_async_count", 133'(count_o), 133'd0);
    exp_q.delete();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    idle(1'b1);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
